// File: rtl/clmul_pkg.sv
// Shared types, constants and result-width helper for the carry-less multiply sequencer.
// CLMUL_SEQ_REDUCE_EN selects the reduced (W-bit) result width in res_w().
package clmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RED,
        DONE
    } state_t;

    localparam int BYTE_W = 8;
    localparam int PP_W   = 2 * BYTE_W - 1;

    function automatic int res_w(input int nbytes);
`ifdef CLMUL_SEQ_REDUCE_EN
        return BYTE_W * nbytes;
`else
        return 2 * BYTE_W * nbytes - 1;
`endif
    endfunction

endpackage

// File: rtl/clmul8.sv
// Combinational 8x8 carry-less (GF(2)[x]) multiplier producing a 15-bit product.
module clmul8
    import clmul_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    output logic [PP_W-1:0]   p_o
);

    always_comb begin
        // NOTE: assign a default before any conditional update so no path leaves p_o unassigned (no latch).
        p_o = '0;
        for (int k = 0; k < BYTE_W; k++) begin
            if (b_i[k]) begin
                p_o = p_o ^ (PP_W'(a_i) << k);
            end
        end
    end

endmodule

// File: rtl/clmul_seq_ctrl.sv
// Byte-serial wide carry-less multiplier reusing one clmul8 across NBYTES^2 cycles.
// Define CLMUL_SEQ_REDUCE_EN to add bit-serial reduction mod POLY and a W-bit result.
module clmul_seq_ctrl
    import clmul_pkg::*;
#(
    parameter int                     NBYTES = 2,
    parameter logic [BYTE_W*NBYTES:0] POLY   = 17'h1002B
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W*NBYTES-1:0]      in_a,
    input  logic [BYTE_W*NBYTES-1:0]      in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [res_w(NBYTES)-1:0]      out_res
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int ACC_W = 2 * W - 1;
    localparam int RES_W = res_w(NBYTES);
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    if (NBYTES < 1 || NBYTES > 8) begin : g_bad_nbytes
        $error("clmul_seq_ctrl: NBYTES must be in 1..8");
    end
    if (POLY[W] != 1'b1) begin : g_bad_poly
        $error("clmul_seq_ctrl: POLY must include the x^W term");
    end

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic [CNT_W-1:0]   j_q, j_d;

`ifdef CLMUL_SEQ_REDUCE_EN
    localparam int K_W = $clog2(ACC_W);
    logic [K_W-1:0]     k_q, k_d;
`endif

    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [PP_W-1:0]    pp;
    logic [ACC_W-1:0]   pp_shifted;

    assign a_byte = a_q[BYTE_W*i_q +: BYTE_W];
    assign b_byte = b_q[BYTE_W*j_q +: BYTE_W];

    clmul8 u_clmul8 (
        .a_i (a_byte),
        .b_i (b_byte),
        .p_o (pp)
    );

    // Byte offsets i+j never exceed 2*(NBYTES-1), so the shifted product fits in 2W-1 bits.
    assign pp_shifted = ACC_W'(pp) << (BYTE_W * (int'(i_q) + int'(j_q)));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
`ifdef CLMUL_SEQ_REDUCE_EN
        k_d     = k_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q ^ pp_shifted;
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        i_d = '0;
`ifdef CLMUL_SEQ_REDUCE_EN
                        k_d     = K_W'(ACC_W - 1);
                        state_d = RED;
`else
                        state_d = DONE;
`endif
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
`ifdef CLMUL_SEQ_REDUCE_EN
            RED: begin
                // Clearing bit k with POLY aligned so its x^W term lands on k.
                if (acc_q[k_q]) begin
                    acc_d = acc_q ^ (ACC_W'(POLY) << (int'(k_q) - W));
                end
                if (k_q == K_W'(W)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
`ifdef CLMUL_SEQ_REDUCE_EN
            k_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
`ifdef CLMUL_SEQ_REDUCE_EN
            k_q     <= k_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_res   = acc_q[RES_W-1:0];

endmodule

// File: tb/tb_clmul_seq_ctrl.sv
// Self-checking bench for clmul_seq_ctrl (NBYTES=2) against a bitwise GF(2) reference model.
// Builds with or without CLMUL_SEQ_REDUCE_EN; expectations follow the same macro.
module tb_clmul_seq_ctrl;

    localparam int          W    = 16;
    localparam logic [16:0] POLY = 17'h1002B;
`ifdef CLMUL_SEQ_REDUCE_EN
    localparam int RES_W   = 16;
    localparam int LAT_EXP = 4 + W;
`else
    localparam int RES_W   = 31;
    localparam int LAT_EXP = 4 + 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_res;

    int n_checks = 0;
    int n_fail   = 0;

    clmul_seq_ctrl #(.NBYTES(2), .POLY(POLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: product as a sum over every bit pair, then polynomial remainder.
    function automatic logic [RES_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] p;
        p = '0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < W; y++)
                if (a[x] && b[y]) p[x+y] = ~p[x+y];
`ifdef CLMUL_SEQ_REDUCE_EN
        for (int k = 2*W-2; k >= W; k--)
            if (p[k]) p = p ^ ((2*W-1)'(POLY) << (k - W));
`endif
        return p[RES_W-1:0];
    endfunction

    // Presents operands until accepted; returns just after the handshake edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output bit to);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        to       = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Latency counts the handshake edge as edge 1.
    task automatic wait_valid(output int lat, output bit to);
        lat = 1;
        to  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [RES_W-1:0] res, output int lat, output bit to);
        bit to_s, to_v;
        send(a, b, to_s);
        wait_valid(lat, to_v);
        res = out_res;
        to  = to_s | to_v;
        if (!to) accept();
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_res=%h, required 1 0 0",
                     in_ready, out_valid, out_res);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [RES_W-1:0] res;
        int lat;
        bit to;
        run_op(16'h0003, 16'h0003, res, lat, to);
        n_checks++;
        if (to || res !== model(16'h0003, 16'h0003)) begin
            n_fail++;
            $display("FAIL basic_result: got %h (timeout=%b), required %h", res, to, model(16'h0003, 16'h0003));
        end
`ifndef CLMUL_SEQ_REDUCE_EN
        n_checks++;
        if (res !== 31'h0000_0005) begin
            n_fail++;
            $display("FAIL basic_const: got %h, required 00000005", res);
        end
`endif
        n_checks++;
        if (lat !== LAT_EXP) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, required %0d", lat, LAT_EXP);
        end
    endtask

    task automatic test_full_width();
        logic [W-1:0]     ops [2] = '{16'hFFFF, 16'h8000};
        logic [RES_W-1:0] res;
        int lat;
        bit to;
        for (int t = 0; t < 2; t++) begin
            run_op(ops[t], ops[t], res, lat, to);
            n_checks++;
            if (to || res !== model(ops[t], ops[t])) begin
                n_fail++;
                $display("FAIL full_width_%0d: got %h (timeout=%b), required %h", t, res, to, model(ops[t], ops[t]));
            end
`ifndef CLMUL_SEQ_REDUCE_EN
            n_checks++;
            if (res !== ((t == 0) ? 31'h5555_5555 : 31'h4000_0000)) begin
                n_fail++;
                $display("FAIL full_width_const_%0d: got %h, required %h",
                         t, res, (t == 0) ? 31'h5555_5555 : 31'h4000_0000);
            end
`endif
        end
    endtask

`ifdef CLMUL_SEQ_REDUCE_EN
    task automatic test_reduce();
        logic [RES_W-1:0] res;
        int lat;
        bit to;
        run_op(16'h8000, 16'h0002, res, lat, to);
        n_checks++;
        if (to || res !== 16'h002B) begin
            n_fail++;
            $display("FAIL reduce_result: got %h (timeout=%b), required 002b", res, to);
        end
        n_checks++;
        if (lat !== 20) begin
            n_fail++;
            $display("FAIL reduce_latency: got %0d edges, required 20", lat);
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [RES_W-1:0] exp_res;
        logic [RES_W-1:0] res;
        int  lat;
        bit  to;
        exp_res = model(16'h00A5, 16'h1C37);
        send(16'h00A5, 16'h1C37, to);
        wait_valid(lat, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL bp_first_valid: out_valid never rose, required 1");
        end
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h4321;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_res !== exp_res || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: out_valid=%b out_res=%h in_ready=%b, required 1 %h 0",
                         c, out_valid, out_res, in_ready, exp_res);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat, to);
        res = out_res;
        n_checks++;
        if (to || res !== model(16'h1234, 16'h4321)) begin
            n_fail++;
            $display("FAIL bp_next_op: got %h (timeout=%b), required %h", res, to, model(16'h1234, 16'h4321));
        end
        if (!to) accept();
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0]     a, b;
        logic [RES_W-1:0] res;
        int  lat;
        bit  to;
        bit  seen;
        a = 16'($urandom);
        b = 16'($urandom) | 16'h0001;
        send(a, b, to);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b out_res=%h, required 0 1 0",
                     out_valid, in_ready, out_res);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midrun_no_result: out_valid seen=1 after release, required 0");
        end
        run_op(b, a, res, lat, to);
        n_checks++;
        if (to || res !== model(b, a)) begin
            n_fail++;
            $display("FAIL midrun_next_op: got %h (timeout=%b), required %h", res, to, model(b, a));
        end
    endtask

    task automatic test_back_to_back();
        logic [RES_W-1:0] q[$];
        logic [RES_W-1:0] exp_res;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_a      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            in_b      = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_result: got %h with nothing outstanding", out_res);
                end else begin
                    exp_res = q.pop_front();
                    if (out_res !== exp_res) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d: got %h, required %h", got, out_res, exp_res);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (got != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d outstanding=%0d, required 1000 0", got, q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_width();
`ifdef CLMUL_SEQ_REDUCE_EN
        test_reduce();
`endif
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
